// File: rtl/enc_130b_gearbox.sv
// 128b/130b transmit encoder: word assembler with optional Gen3 scrambling,
// followed by a 260-bit gearbox that drains OUT_W bits per cycle, bit 0 first.
module enc_130b_gearbox #(
  parameter int          DATA_W = 8,
  parameter int          OUT_W  = 1,
  parameter logic [22:0] SEED   = 23'h1DBFBC
) (
  input  logic              clk1,
  input  logic              rst1,
  input  logic [1:0]        scr_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_start,
  input  logic              in_k,
  input  logic [DATA_W-1:0] in_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic [15:0]       blk_cnt,
  output logic              err
);

  localparam int unsigned NW       = 128 / DATA_W;
  localparam logic [4:0]  NW5      = 5'(NW);
  localparam logic [22:0] TAPS     = 23'h210125;
  localparam logic [8:0]  FILL_MAX = 9'd260;
  localparam logic [8:0]  BLK_LEN  = 9'd130;
  localparam logic [8:0]  OUT_LEN  = 9'(OUT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [127:0]        pay_q, pay_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                k_q, k_d;
  logic [1:0]          mode_q, mode_d;
  logic [22:0]         lfsr_q, lfsr_d;
  logic [259:0]        buf_q, buf_d;
  logic [8:0]          fill_q, fill_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [15:0]         blk_cnt_q, blk_cnt_d;
  logic                err_q, err_d;

  logic                accept, word_acc, blk_k, scr_en, emit, load;
  logic [1:0]          blk_mode;
  logic [22:0]         lfsr_w;
  logic [DATA_W-1:0]   scr_word;
  logic [4:0]          wr_idx;
  logic [8:0]          fill_em;
  logic [129:0]        blk;
  logic [259:0]        buf_sh;

  always_ff @(posedge clk1) begin
    if (rst1) begin
      state_q     <= IDLE;
      pay_q       <= '0;
      cnt_q       <= '0;
      k_q         <= 1'b0;
      mode_q      <= '0;
      lfsr_q      <= SEED;
      buf_q       <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      blk_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pay_q       <= pay_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      lfsr_q      <= lfsr_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      blk_cnt_q   <= blk_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && in_start) state_d = (NW == 1) ? PEND : FILL;
      FILL: begin
        if (accept) begin
          if (in_start)                 state_d = FILL;
          else if (cnt_q + 5'd1 == NW5) state_d = PEND;
        end
      end
      PEND: if (load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q != PEND);
    accept   = in_valid && in_ready;
  end

  // A start word uses its own in_k/scr_mode; later words use the latched copies.
  always_comb begin
    blk_k    = in_start ? in_k : k_q;
    blk_mode = in_start ? scr_mode : mode_q;
    scr_en   = (blk_mode == 2'd2) || ((blk_mode != 2'd0) && !blk_k);
    lfsr_w   = (in_start && in_k && (scr_mode == 2'd3)) ? SEED : lfsr_q;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      scr_word[i] = in_data[i];
      if (scr_en) begin
        scr_word[i] = in_data[i] ^ lfsr_w[22];
        lfsr_w      = {lfsr_w[21:0], 1'b0} ^ (lfsr_w[22] ? TAPS : '0);
      end
    end
    wr_idx   = in_start ? '0 : cnt_q;
    word_acc = accept && (in_start || (state_q == FILL));
    pay_d    = pay_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    mode_d   = mode_q;
    lfsr_d   = lfsr_q;
    if (word_acc) begin
      for (int unsigned w = 0; w < NW; w++) begin
        if (wr_idx == 5'(w)) pay_d[w*DATA_W +: DATA_W] = scr_word;
      end
      cnt_d  = wr_idx + 5'd1;
      k_d    = blk_k;
      mode_d = blk_mode;
      lfsr_d = lfsr_w;
    end
    err_d = accept && (((state_q == IDLE) && !in_start) ||
                       ((state_q == FILL) && in_start));
  end

  // The space test uses the fill left after this cycle's emit, so a block can
  // be appended in the same cycle the oldest bits leave.
  always_comb begin
    emit      = (fill_q >= OUT_LEN);
    fill_em   = emit ? (fill_q - OUT_LEN) : fill_q;
    load      = (state_q == PEND) && ((fill_em + BLK_LEN) <= FILL_MAX);
    blk       = {pay_q, (k_q ? 2'b01 : 2'b10)};
    buf_sh    = emit ? (buf_q >> OUT_W) : buf_q;
    buf_d     = buf_sh;
    fill_d    = fill_em;
    blk_cnt_d = blk_cnt_q;
    if (load) begin
      buf_d     = buf_sh | ({130'b0, blk} << fill_em);
      fill_d    = fill_em + BLK_LEN;
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
    out_valid_d = emit;
    out_data_d  = emit ? buf_q[OUT_W-1:0] : out_data_q;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign blk_cnt   = blk_cnt_q;
  assign err       = err_q;

endmodule
